timer_core_param: RTL and testbench

- Parametrised minutes:seconds timer engine; successor to the fixed countdown timer, with the display removed.
- Adds: generic clock/tick rates, configurable minute range, count-down and count-up (stopwatch) modes, a pause state, and an alarm/done state.
- Driven by the debounced front-panel buttons.
- Time fields and status feed the VGA character renderer and any future 7-segment path.

---
 rtl/timer_core_param.sv | 150 +++++++++++++++
 tb/tb_timer_core_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_core_param.sv
// Minutes:seconds timer engine with count-down/up modes, pause and done/alarm states.
// Button inputs are debounced levels; each rising edge produces one action.
module timer_core_param #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned MAX_MIN     = 99,
  parameter int unsigned MIN_W       = 7
) (
  input  logic             CLK_50MHZ,
  input  logic             reset,
  input  logic             mode,
  input  logic             incrementSeconds,
  input  logic             incrementMinutes,
  input  logic             start,
  input  logic             stop,
  input  logic             delete,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [1:0]       state,
  output logic             alarm,
  output logic             tick
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    DivM1  = PW'(DIV - 1);
  localparam logic [MIN_W-1:0] MaxMin = MIN_W'(MAX_MIN);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2, StDone = 2'd3} state_e;

  state_e           r_state_q, r_state_d;
  logic [MIN_W-1:0] r_min_q, r_min_d;
  logic [5:0]       r_sec_q, r_sec_d;
  logic [PW-1:0]    r_presc_q, r_presc_d;
  logic             r_tick_q, r_tick_d;
  logic             r_mode_q, r_mode_d;
  logic [4:0]       r_btn_q;

  logic [4:0] w_btn;
  logic [4:0] w_ev;
  logic       w_ev_start, w_ev_stop, w_ev_del, w_ev_isec, w_ev_imin;
  logic       w_time_zero;

  assign w_btn       = {incrementMinutes, incrementSeconds, delete, stop, start};
  assign w_ev        = w_btn & ~r_btn_q;
  assign w_ev_start  = w_ev[0];
  assign w_ev_stop   = w_ev[1];
  assign w_ev_del    = w_ev[2];
  assign w_ev_isec   = w_ev[3];
  assign w_ev_imin   = w_ev[4];
  assign w_time_zero = (r_min_q == '0) && (r_sec_q == 6'd0);

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      r_state_q <= StIdle;
      r_min_q   <= '0;
      r_sec_q   <= 6'd0;
      r_presc_q <= '0;
      r_tick_q  <= 1'b0;
      r_mode_q  <= 1'b0;
      r_btn_q   <= 5'd0;
    end else begin
      r_state_q <= r_state_d;
      r_min_q   <= r_min_d;
      r_sec_q   <= r_sec_d;
      r_presc_q <= r_presc_d;
      r_tick_q  <= r_tick_d;
      r_mode_q  <= r_mode_d;
      r_btn_q   <= w_btn;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_min_d   = r_min_q;
    r_sec_d   = r_sec_q;
    r_presc_d = r_presc_q;
    r_tick_d  = 1'b0;
    r_mode_d  = r_mode_q;

    if (w_ev_del) begin
      r_state_d = StIdle;
      r_min_d   = '0;
      r_sec_d   = 6'd0;
      r_presc_d = '0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          // A count-down start from 00:00 is swallowed; increments still apply then.
          if (w_ev_start && (mode || !w_time_zero)) begin
            r_mode_d  = mode;
            r_state_d = StRun;
            r_presc_d = '0;
          end else if (!w_ev_stop) begin
            if (w_ev_isec) r_sec_d = (r_sec_q == 6'd59) ? 6'd0 : r_sec_q + 6'd1;
            if (w_ev_imin) r_min_d = (r_min_q == MaxMin) ? '0 : r_min_q + MIN_W'(1);
          end
        end
        StRun: begin
          if (w_ev_stop) begin
            r_state_d = StPause;
          end else if (r_presc_q != DivM1) begin
            r_presc_d = r_presc_q + PW'(1);
          end else begin
            r_presc_d = '0;
            r_tick_d  = 1'b1;
            if (!r_mode_q) begin
              if (r_sec_q == 6'd0) begin
                r_sec_d = 6'd59;
                r_min_d = r_min_q - MIN_W'(1);
              end else begin
                r_sec_d = r_sec_q - 6'd1;
              end
              if ((r_min_q == '0) && (r_sec_q == 6'd1)) r_state_d = StDone;
            end else if ((r_min_q == MaxMin) && (r_sec_q == 6'd59)) begin
              r_state_d = StDone;
            end else begin
              if (r_sec_q == 6'd59) begin
                r_sec_d = 6'd0;
                r_min_d = r_min_q + MIN_W'(1);
              end else begin
                r_sec_d = r_sec_q + 6'd1;
              end
              if ((r_min_q == MaxMin) && (r_sec_q == 6'd58)) r_state_d = StDone;
            end
          end
        end
        StPause: begin
          if (w_ev_start && !w_ev_stop) r_state_d = StRun;
        end
        StDone: begin
          if (w_ev_start || w_ev_stop) begin
            r_state_d = StIdle;
            r_min_d   = '0;
            r_sec_d   = 6'd0;
            r_presc_d = '0;
          end
        end
        default: r_state_d = StIdle;
      endcase
    end
  end

  assign minutes = r_min_q;
  assign seconds = r_sec_q;
  assign state   = r_state_q;
  assign alarm   = (r_state_q == StDone);
  assign tick    = r_tick_q;

endmodule

// File: tb/tb_timer_core_param.sv
// Directed bench for timer_core_param with DIV = 10, MAX_MIN = 3.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_timer_core_param;

  localparam int BStart = 0;
  localparam int BStop  = 1;
  localparam int BDel   = 2;
  localparam int BIsec  = 3;
  localparam int BImin  = 4;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [4:0] btns;
  logic [1:0] minutes;
  logic [5:0] seconds;
  logic [1:0] state;
  logic       alarm;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  timer_core_param #(
    .CLK_FREQ_HZ(10),
    .TICK_HZ    (1),
    .MAX_MIN    (3),
    .MIN_W      (2)
  ) u_dut (
    .CLK_50MHZ       (clk),
    .reset           (rst_n),
    .mode            (mode),
    .incrementSeconds(btns[BIsec]),
    .incrementMinutes(btns[BImin]),
    .start           (btns[BStart]),
    .stop            (btns[BStop]),
    .delete          (btns[BDel]),
    .minutes         (minutes),
    .seconds         (seconds),
    .state           (state),
    .alarm           (alarm),
    .tick            (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Button high for exactly one edge (the event edge), then released.
  task automatic press(input int b);
    btns[b] = 1'b1;
    step(1);
    btns[b] = 1'b0;
  endtask

  task automatic tap(input int b);
    press(b);
    step(1);
  endtask

  task automatic load(input int m, input int s);
    tap(BDel);
    repeat (m) tap(BImin);
    repeat (s) tap(BIsec);
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b0;
    btns  = 5'd0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_min", minutes, 0);
    check("rst_sec", seconds, 0);
    check("rst_state", state, 0);
    check("rst_alarm", alarm, 0);
    check("rst_tick", tick, 0);
    tap(BStart);
    check("zero_start_ignored", state, 0);

    // Setup wraps
    repeat (61) tap(BIsec);
    check("sec_wrap_sec", seconds, 1);
    check("sec_wrap_min", minutes, 0);
    repeat (5) tap(BImin);
    check("min_wrap", minutes, 1);
    btns[BIsec] = 1'b1;
    step(20);
    btns[BIsec] = 1'b0;
    step(1);
    check("hold_one_event", seconds, 2);
    check("hold_min", minutes, 1);

    // Countdown 0:02
    load(0, 2);
    mode = 1'b0;
    press(BStart);
    check("cd_run", state, 1);
    step(9);
    check("cd_e9_sec", seconds, 2);
    check("cd_e9_tick", tick, 0);
    step(1);
    check("cd_e10_sec", seconds, 1);
    check("cd_e10_tick", tick, 1);
    step(1);
    check("cd_tick_pulse", tick, 0);
    step(9);
    check("cd_e20_sec", seconds, 0);
    check("cd_e20_min", minutes, 0);
    check("cd_done_state", state, 3);
    check("cd_alarm", alarm, 1);
    step(5);
    check("cd_done_hold", state, 3);
    press(BStop);
    check("cd_ack_state", state, 0);
    check("cd_ack_alarm", alarm, 0);

    // Pause / resume from 1:00
    load(1, 0);
    press(BStart);
    step(10);
    check("pr_e10_sec", seconds, 59);
    check("pr_e10_min", minutes, 0);
    step(5);
    press(BStop);
    check("pr_pause", state, 2);
    tap(BIsec);
    step(48);
    check("pr_frozen_sec", seconds, 59);
    check("pr_frozen_min", minutes, 0);
    check("pr_still_pause", state, 2);
    press(BStart);
    check("pr_resume", state, 1);
    step(4);
    check("pr_before_tick", seconds, 59);
    step(1);
    check("pr_after_tick", seconds, 58);
    check("pr_tick", tick, 1);

    // Count up from 3:57 with mode toggled during RUN
    load(3, 57);
    check("up_load_min", minutes, 3);
    check("up_load_sec", seconds, 57);
    mode = 1'b1;
    press(BStart);
    mode = 1'b0;
    step(10);
    check("up_e10_sec", seconds, 58);
    check("up_e10_state", state, 1);
    step(10);
    check("up_e20_sec", seconds, 59);
    check("up_e20_min", minutes, 3);
    check("up_done", state, 3);
    check("up_alarm", alarm, 1);
    press(BStart);
    check("up_ack_state", state, 0);
    check("up_ack_sec", seconds, 0);
    check("up_ack_min", minutes, 0);

    // Increments ignored in RUN; delete beats stop
    load(0, 5);
    mode = 1'b0;
    press(BStart);
    step(3);
    press(BIsec);
    check("run_inc_ignored", seconds, 5);
    check("run_state", state, 1);
    btns[BDel]  = 1'b1;
    btns[BStop] = 1'b1;
    step(1);
    btns[BDel]  = 1'b0;
    btns[BStop] = 1'b0;
    check("prio_state", state, 0);
    check("prio_sec", seconds, 0);
    check("prio_min", minutes, 0);
    step(15);
    check("prio_idle_stays", state, 0);
    check("prio_no_alarm", alarm, 0);

    // Async reset mid-RUN
    load(0, 3);
    press(BStart);
    step(12);
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_sec", seconds, 0);
    check("arst_alarm", alarm, 0);
    step(2);
    rst_n = 1'b1;
    step(30);
    check("arst_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
